// File: rtl/decode_rename_fifo_pkg.sv
// Shared types and helpers for the decode-to-rename queue.
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 3
`endif
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 3
`endif

package decode_rename_fifo_pkg;

  // One decoded instruction handed from decode to rename.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } decode_rename_pack_t;

  // Number of set bits in a mask of up to 32 bits.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += {31'd0, v[i]};
    return n;
  endfunction

  // True when the mask has the form 0..01..1 (including all zeros).
  function automatic logic is_prefix_mask(input logic [31:0] m);
    return ((m & (m + 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/decode_rename_fifo_compactor.sv
// Maps the write-slot valid mask onto dense storage offsets so that
// accepted entries land back to back starting at the write pointer.
module fifo_compactor #(
  parameter int PUSH_WIDTH = 3,
  parameter int OW         = $clog2(PUSH_WIDTH + 1)
) (
  input  logic [PUSH_WIDTH-1:0] valid,
  input  logic [PUSH_WIDTH-1:0] enable,
  output logic [PUSH_WIDTH-1:0] accept,
  output logic [OW-1:0]         offset [PUSH_WIDTH],
  output logic [OW-1:0]         n_push
);

  // Each accepted slot's offset is the number of accepted slots below it.
  always_comb begin
    logic [OW-1:0] run;
    run    = '0;
    accept = valid & enable;
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      offset[i] = run;
      run       = run + OW'(accept[i]);
    end
    n_push = run;
  end

endmodule

// File: rtl/decode_rename_fifo.sv
// Multi-port circular queue between decode (writer) and rename (reader).
// All outputs depend only on registered state.
module decode_rename_fifo
  import decode_rename_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int PUSH_WIDTH = `DECODE_WIDTH,
  parameter int POP_WIDTH  = `RENAME_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PUSH_WIDTH-1:0]     decode_rename_fifo_data_in_enable,
  input  decode_rename_pack_t       decode_rename_fifo_data_in [PUSH_WIDTH],
  input  logic [PUSH_WIDTH-1:0]     decode_rename_fifo_data_in_valid,
  input  logic                      decode_rename_fifo_push,
  input  logic                      decode_rename_fifo_flush,
  output decode_rename_pack_t       decode_rename_fifo_data_out [POP_WIDTH],
  output logic [POP_WIDTH-1:0]      decode_rename_fifo_data_out_valid,
  input  logic [POP_WIDTH-1:0]      decode_rename_fifo_data_pop_valid,
  input  logic                      decode_rename_fifo_pop,
  output logic                      decode_rename_fifo_full,
  output logic [$clog2(DEPTH):0]    decode_rename_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(PUSH_WIDTH + 1);

  decode_rename_pack_t mem [DEPTH];
  logic [AW-1:0]       rptr;
  logic [AW-1:0]       wptr;
  logic [CW-1:0]       count;

  logic [CW-1:0]         free;
  logic [PUSH_WIDTH-1:0] accept;
  logic [OW-1:0]         offset [PUSH_WIDTH];
  logic [OW-1:0]         n_push;
  logic                  do_push;
  logic                  do_pop;
  logic [OW-1:0]         n_push_eff;
  logic [CW-1:0]         n_pop;
  logic [CW-1:0]         count_next;

  fifo_compactor #(
    .PUSH_WIDTH (PUSH_WIDTH),
    .OW         (OW)
  ) u_compactor (
    .valid  (decode_rename_fifo_data_in_valid),
    .enable (decode_rename_fifo_data_in_enable),
    .accept (accept),
    .offset (offset),
    .n_push (n_push)
  );

  // Thermometer space/occupancy views and the head window, from state only.
  always_comb begin
    free = CW'(DEPTH) - count;
    for (int i = 0; i < PUSH_WIDTH; i++)
      decode_rename_fifo_data_in_enable[i] = (free > CW'(i));
    for (int i = 0; i < POP_WIDTH; i++) begin
      decode_rename_fifo_data_out_valid[i] = (count > CW'(i));
      decode_rename_fifo_data_out[i]       = mem[rptr + AW'(i)];
    end
    decode_rename_fifo_full  = (count == CW'(DEPTH));
    decode_rename_fifo_count = count;
  end

  // Flush overrides both ports; pop size is the length of the prefix mask.
  always_comb begin
    do_push    = decode_rename_fifo_push & ~decode_rename_fifo_flush;
    do_pop     = decode_rename_fifo_pop & ~decode_rename_fifo_flush;
    n_push_eff = do_push ? n_push : '0;
    n_pop      = do_pop ? CW'(popcount(32'(decode_rename_fifo_data_pop_valid))) : '0;
    count_next = count + CW'(n_push_eff) - n_pop;
  end

  // Pointer and occupancy registers; reset outranks flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (decode_rename_fifo_flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(n_push_eff);
      rptr  <= rptr + AW'(n_pop);
      count <= count_next;
    end
  end

  // Storage writes: accepted slots packed densely from wptr, wrapping.
  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      for (int i = 0; i < PUSH_WIDTH; i++)
        if (accept[i]) mem[wptr + AW'(offset[i])] <= decode_rename_fifo_data_in[i];
    end
  end

  // Rename may only consume a prefix of the entries currently presented.
  a_pop_prefix: assert property (@(posedge clk) disable iff (!rst)
    do_pop |-> (is_prefix_mask(32'(decode_rename_fifo_data_pop_valid)) &&
                ((decode_rename_fifo_data_pop_valid & ~decode_rename_fifo_data_out_valid) == '0)));

endmodule
